// File: rtl/fetch_pc_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, registers {pc, instr} into the IF/ID slot.
// Slot valid the cycle after rvalid; if IF/ID is stalled, the response is parked in a 1-entry buffer.
module fetch_pc_stage #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] next_pc_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ifid_valid,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [DATA_W-1:0] ifid_instr,
    input  logic              ifid_ready
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic              discard, discard_nxt;
    logic [DATA_W-1:0] buf_dat, buf_nxt;
    logic              vld_q, vld_nxt;
    logic [ADDR_W-1:0] ipc_q, ipc_nxt;
    logic [DATA_W-1:0] ins_q, ins_nxt;

    logic              slot_free;
    logic              flush_act;
    logic              accept;
    logic [DATA_W-1:0] accept_dat;

    assign pc_out     = pc_q;
    assign pc_plus1   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc_q;
    assign ifid_valid = vld_q;
    assign ifid_pc    = ipc_q;
    assign ifid_instr = ins_q;

    assign slot_free = !vld_q || ifid_ready;
    assign flush_act = flush && (state != S_BOOT);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        discard_nxt = discard;
        buf_nxt     = buf_dat;
        vld_nxt     = vld_q;
        ipc_nxt     = ipc_q;
        ins_nxt     = ins_q;
        accept      = 1'b0;
        accept_dat  = imem_rdata;

        case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ: begin
                // A grant coinciding with flush belongs to the old address; its response must be dropped.
                if (imem_gnt) begin
                    state_nxt = S_WAIT;
                    if (flush_act) discard_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush_act) begin
                    if (imem_rvalid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_REQ;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    if (discard) begin
                        discard_nxt = 1'b0;
                    end else if (slot_free) begin
                        accept = 1'b1;
                    end else begin
                        buf_nxt   = imem_rdata;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush_act) begin
                    state_nxt = S_REQ;
                end else if (slot_free) begin
                    accept     = 1'b1;
                    accept_dat = buf_dat;
                    state_nxt  = S_REQ;
                end
            end
            default: state_nxt = S_BOOT;
        endcase

        if (flush_act) begin
            pc_nxt  = next_pc_in;
            vld_nxt = 1'b0;
        end else if (accept) begin
            ipc_nxt = pc_q;
            ins_nxt = accept_dat;
            vld_nxt = 1'b1;
            pc_nxt  = next_pc_in;
        end else if (vld_q && ifid_ready) begin
            vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            pc_q    <= RESET_PC;
            discard <= 1'b0;
            buf_dat <= '0;
            vld_q   <= 1'b0;
            ipc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            discard <= discard_nxt;
            buf_dat <= buf_nxt;
            vld_q   <= vld_nxt;
            ipc_q   <= ipc_nxt;
            ins_q   <= ins_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: behavioural imem with programmable latency, next-PC select model, IF/ID capture queue.
module tb_fetch_pc_stage;

    localparam logic [19:0] KEY = 20'hABCDE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] next_pc_in;
    logic [19:0] pc_out, pc_plus1;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [19:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [19:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [19:0] ifid_pc, ifid_instr;
    logic        ifid_ready = 1'b1;

    logic        use_tgt = 1'b0;
    logic [19:0] tgt = '0;
    assign next_pc_in = use_tgt ? tgt : pc_plus1;

    int          n_vec = 0;
    int          n_err = 0;

    logic        mem_clear = 1'b0;
    logic        pend = 1'b0;
    logic [19:0] pend_addr = '0;
    int          wait_cnt = 0;
    int          extra_lat = 0;

    logic [39:0] got[$];

    fetch_pc_stage #(.ADDR_W(20), .DATA_W(20), .RESET_PC(20'h00000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc_in  (next_pc_in),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .ifid_ready  (ifid_ready)
    );

    always #5 clk = ~clk;

    // Memory: responds (extra_lat+1) cycles after a grant with addr^KEY; driven 2 time units after negedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mem_clear) begin
                pend        = 1'b0;
                imem_rvalid = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (pend) begin
                    if (wait_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = pend_addr ^ KEY;
                        pend        = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (imem_req && imem_gnt && !pend) begin
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    wait_cnt  = extra_lat;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && ifid_valid && ifid_ready) got.push_back({ifid_pc, ifid_instr});
        end
    end

    task automatic chk_vec(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_got(input string tag, input int n);
        int budget = 60;
        while (got.size() < n && budget > 0) begin
            tick(1);
            budget--;
        end
        chk_vec(tag, 40'(got.size() >= n), 40'd1);
    endtask

    task automatic exp_got(input string tag, input int idx, input logic [19:0] pc);
        logic [39:0] e;
        e = (idx < got.size()) ? got[idx] : '1;
        chk_vec({tag, "_pc"}, 40'(e[39:20]), 40'(pc));
        chk_vec({tag, "_instr"}, 40'(e[19:0]), 40'(pc ^ KEY));
    endtask

    // Leaves the bench at the release negedge (BOOT cycle).
    task automatic do_reset(input int lat, input logic gnt);
        rst_n      = 1'b0;
        mem_clear  = 1'b1;
        flush      = 1'b0;
        use_tgt    = 1'b0;
        ifid_ready = 1'b1;
        imem_gnt   = gnt;
        extra_lat  = lat;
        tick(2);
        got.delete();
        mem_clear = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        // Reset state and sequential fetch 0..3
        tick(1);
        chk_vec("rst_pc", 40'(pc_out), 40'h0);
        chk_vec("rst_req", 40'(imem_req), 40'h0);
        chk_vec("rst_valid", 40'(ifid_valid), 40'h0);
        chk_vec("rst_ifid_pc", 40'(ifid_pc), 40'h0);
        chk_vec("rst_ifid_instr", 40'(ifid_instr), 40'h0);
        do_reset(0, 1'b1);
        chk_vec("boot_req", 40'(imem_req), 40'h0);
        tick(1);
        chk_vec("req_after_boot", 40'(imem_req), 40'h1);
        chk_vec("req_addr0", 40'(imem_addr), 40'h0);
        tick(2);
        chk_vec("lat_valid", 40'(ifid_valid), 40'h1);
        chk_vec("lat_pc", 40'(ifid_pc), 40'h0);
        chk_vec("lat_instr", 40'(ifid_instr), 40'(20'h0 ^ KEY));
        chk_vec("pc_adv", 40'(pc_out), 40'h1);
        chk_vec("pc_plus1", 40'(pc_plus1), 40'h2);
        wait_got("seq_wait", 4);
        for (int i = 0; i < 4; i++) exp_got("seq", i, 20'(i));

        // PC wrap at 20'hFFFFF; address held while no grant
        do_reset(0, 1'b0);
        tick(3);
        chk_vec("nognt_req", 40'(imem_req), 40'h1);
        chk_vec("nognt_addr", 40'(imem_addr), 40'h0);
        flush   = 1'b1;
        use_tgt = 1'b1;
        tgt     = 20'hFFFFF;
        tick(1);
        flush   = 1'b0;
        use_tgt = 1'b0;
        chk_vec("wrap_pc", 40'(pc_out), 40'hFFFFF);
        chk_vec("wrap_plus1", 40'(pc_plus1), 40'h0);
        chk_vec("wrap_addr", 40'(imem_addr), 40'hFFFFF);
        imem_gnt = 1'b1;
        wait_got("wrap_wait", 2);
        exp_got("wrap0", 0, 20'hFFFFF);
        exp_got("wrap1", 1, 20'h00000);

        // IF/ID stall: second response parked in S_HOLD, then both delivered in order
        begin
            int bud = 20;
            int req_cnt = 0;
            do_reset(0, 1'b1);
            tick(1);
            while (!ifid_valid && bud > 0) begin
                tick(1);
                bud--;
            end
            ifid_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick(1);
                if (imem_req) req_cnt++;
            end
            chk_vec("stall_req_cnt", 40'(req_cnt), 40'h0);
            chk_vec("stall_valid", 40'(ifid_valid), 40'h1);
            chk_vec("stall_ifid_pc", 40'(ifid_pc), 40'h0);
            chk_vec("stall_pc", 40'(pc_out), 40'h1);
            chk_vec("stall_nopush", 40'(got.size()), 40'h0);
            ifid_ready = 1'b1;
            wait_got("stall_wait", 3);
            for (int i = 0; i < 3; i++) exp_got("stall_seq", i, 20'(i));
        end

        // Flush in S_WAIT, response arrives one cycle later and is discarded
        do_reset(1, 1'b1);
        tick(2);
        flush   = 1'b1;
        use_tgt = 1'b1;
        tgt     = 20'h00400;
        tick(1);
        flush   = 1'b0;
        use_tgt = 1'b0;
        chk_vec("fw_valid", 40'(ifid_valid), 40'h0);
        chk_vec("fw_pc", 40'(pc_out), 40'h00400);
        chk_vec("fw_req_wait", 40'(imem_req), 40'h0);
        tick(1);
        chk_vec("fw_req", 40'(imem_req), 40'h1);
        chk_vec("fw_addr", 40'(imem_addr), 40'h00400);
        wait_got("fw_wait", 1);
        exp_got("fw_first", 0, 20'h00400);

        // Flush together with rvalid
        do_reset(0, 1'b1);
        tick(2);
        flush   = 1'b1;
        use_tgt = 1'b1;
        tgt     = 20'h00800;
        tick(1);
        flush   = 1'b0;
        use_tgt = 1'b0;
        chk_vec("frv_valid", 40'(ifid_valid), 40'h0);
        chk_vec("frv_req", 40'(imem_req), 40'h1);
        chk_vec("frv_addr", 40'(imem_addr), 40'h00800);
        wait_got("frv_wait", 1);
        exp_got("frv_first", 0, 20'h00800);

        // Flush together with gnt in S_REQ
        do_reset(0, 1'b1);
        tick(1);
        flush   = 1'b1;
        use_tgt = 1'b1;
        tgt     = 20'h00C00;
        tick(1);
        flush   = 1'b0;
        use_tgt = 1'b0;
        chk_vec("fg_req_wait", 40'(imem_req), 40'h0);
        chk_vec("fg_pc", 40'(pc_out), 40'h00C00);
        tick(1);
        chk_vec("fg_valid", 40'(ifid_valid), 40'h0);
        chk_vec("fg_req", 40'(imem_req), 40'h1);
        chk_vec("fg_addr", 40'(imem_addr), 40'h00C00);
        wait_got("fg_wait", 1);
        exp_got("fg_first", 0, 20'h00C00);

        // Async reset in S_WAIT; the stale response lands during BOOT
        do_reset(0, 1'b1);
        ifid_ready = 1'b0;
        tick(2);
        extra_lat = 2;
        tick(2);
        chk_vec("ar_pre_valid", 40'(ifid_valid), 40'h1);
        rst_n    = 1'b0;
        imem_gnt = 1'b0;
        #1;
        chk_vec("ar_req", 40'(imem_req), 40'h0);
        chk_vec("ar_valid", 40'(ifid_valid), 40'h0);
        chk_vec("ar_pc", 40'(pc_out), 40'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk_vec("ar_late_valid", 40'(ifid_valid), 40'h0);
        chk_vec("ar_late_req", 40'(imem_req), 40'h1);
        chk_vec("ar_late_addr", 40'(imem_addr), 40'h0);
        tick(1);
        chk_vec("ar_late_valid2", 40'(ifid_valid), 40'h0);
        extra_lat  = 0;
        imem_gnt   = 1'b1;
        ifid_ready = 1'b1;
        wait_got("ar_wait", 1);
        exp_got("ar_first", 0, 20'h00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
